// File: rtl/sys_defs.sv
// Shared sizing constants and helpers for the CDB completion arbiter.
package sys_defs;

  localparam int N             = 3;
  localparam int NUM_FU_ALU    = 3;
  localparam int NUM_FU_MULT   = 2;
  localparam int NUM_FU_BRANCH = 1;
  localparam int NUM_FU_LDST   = 1;
  localparam int NUM_FU_TOTAL  = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_BRANCH + NUM_FU_LDST;
  localparam int B_MASK        = 4;
  localparam int STARVE_LIMIT  = 4;

  // FU index layout: ALUs lowest, then mults, branch, load/store highest
  localparam int ALU_BASE    = 0;
  localparam int MULT_BASE   = ALU_BASE + NUM_FU_ALU;
  localparam int BRANCH_BASE = MULT_BASE + NUM_FU_MULT;
  localparam int LDST_BASE   = BRANCH_BASE + NUM_FU_BRANCH;

  localparam int FU_IDX_W   = $clog2(NUM_FU_TOTAL);
  localparam int AGE_W      = $clog2(STARVE_LIMIT + 1);
  localparam int SLOT_CNT_W = $clog2(N + 1);

  typedef logic [NUM_FU_TOTAL-1:0] fu_vec_t;
  typedef logic [FU_IDX_W-1:0]     fu_idx_t;
  typedef logic [AGE_W-1:0]        age_t;

  // Encode a one-hot FU vector to its index (zero vector maps to 0)
  function automatic fu_idx_t onehot_to_idx(input fu_vec_t v);
    fu_idx_t r;
    r = '0;
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      if (v[i]) r = fu_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/cdb_complete_arbiter_rr_first_select.sv
// Picks the first set request bit at or after a start pointer, wrapping.
module rr_first_select #(
  parameter int W  = 7,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [W-1:0]  gnt_o
);

  // Walk indices in rotated order from ptr_i, keep only the first hit
  always_comb begin
    int  pos;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < W; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= W) pos = pos - W;
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// Grants up to N CDB completion slots per cycle: round-robin from rr_ptr,
// with slot 0 overridden by the lowest-index starved requester.
module cdb_complete_arbiter
  import sys_defs::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_FU_TOTAL-1:0]              fu_req,
  input  logic [NUM_FU_TOTAL-1:0][B_MASK-1:0]  fu_b_mask,
  input  logic [B_MASK-1:0]                    b_mm_resolve,
  input  logic                                 b_mm_mispred,
  output logic [N-1:0][NUM_FU_TOTAL-1:0]       complete_gnt_bus,
  output logic [NUM_FU_ALU-1:0]                alu_cdb_en,
  output logic [NUM_FU_MULT-1:0]               mult_cdb_en,
  output logic [NUM_FU_BRANCH-1:0]             branch_cdb_en,
  output logic [NUM_FU_LDST-1:0]               ldst_cdb_en,
  output logic [SLOT_CNT_W-1:0]                slots_used
);

  fu_idx_t rr_ptr_q, rr_ptr_d;
  age_t    age_q [NUM_FU_TOTAL];
  age_t    age_d [NUM_FU_TOTAL];

  fu_vec_t kill, elig, starved, starve_gnt, granted, granted_out;
  fu_vec_t rr_gnt   [N];
  fu_vec_t slot_gnt [N];
  fu_vec_t taken    [N+1];

  // Squash requests on the mispredicted path first, then find starved units
  always_comb begin
    kill    = '0;
    starved = '0;
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      kill[i] = b_mm_mispred & (|(fu_b_mask[i] & b_mm_resolve));
    end
    elig = fu_req & ~kill;
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      starved[i] = elig[i] & (age_q[i] >= age_t'(STARVE_LIMIT));
    end
  end

  // Lowest-index starved requester (downward scan so the lowest wins)
  always_comb begin
    starve_gnt = '0;
    for (int i = NUM_FU_TOTAL - 1; i >= 0; i--) begin
      if (starved[i]) starve_gnt = fu_vec_t'(1) << i;
    end
  end

  // Slot chain: each stage picks from what earlier slots left over
  assign taken[0] = '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      rr_first_select #(.W(NUM_FU_TOTAL)) u_sel (
        .req_i (elig & ~taken[gi]),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt[gi])
      );
      if (gi == 0) begin : g_head
        assign slot_gnt[gi] = (|starved) ? starve_gnt : rr_gnt[gi];
      end else begin : g_tail
        assign slot_gnt[gi] = rr_gnt[gi];
      end
      assign taken[gi+1] = taken[gi] | slot_gnt[gi];
    end
  endgenerate

  assign granted     = taken[N];
  assign granted_out = reset ? '0 : granted;

  assign alu_cdb_en    = granted_out[ALU_BASE    +: NUM_FU_ALU];
  assign mult_cdb_en   = granted_out[MULT_BASE   +: NUM_FU_MULT];
  assign branch_cdb_en = granted_out[BRANCH_BASE +: NUM_FU_BRANCH];
  assign ldst_cdb_en   = granted_out[LDST_BASE   +: NUM_FU_LDST];

  // Drive the slot bus and slot count, forced quiet while in reset
  always_comb begin
    complete_gnt_bus = '0;
    slots_used       = '0;
    if (!reset) begin
      for (int s = 0; s < N; s++) begin
        complete_gnt_bus[s] = slot_gnt[s];
        slots_used          = slots_used + SLOT_CNT_W'(|slot_gnt[s]);
      end
    end
  end

  // Next pointer follows the highest filled slot; ages track losing waits
  always_comb begin
    fu_idx_t last;
    last     = '0;
    rr_ptr_d = rr_ptr_q;
    for (int s = 0; s < N; s++) begin
      if (|slot_gnt[s]) begin
        last     = onehot_to_idx(slot_gnt[s]);
        rr_ptr_d = (last == fu_idx_t'(NUM_FU_TOTAL - 1)) ? '0 : fu_idx_t'(last + fu_idx_t'(1));
      end
    end
    for (int i = 0; i < NUM_FU_TOTAL; i++) begin
      if (kill[i]) begin
        age_d[i] = '0;
      end else if (!(|elig)) begin
        age_d[i] = age_q[i];
      end else if (elig[i] && !granted[i]) begin
        age_d[i] = (age_q[i] == age_t'(STARVE_LIMIT)) ? age_q[i] : age_q[i] + age_t'(1);
      end else begin
        age_d[i] = '0;
      end
    end
  end

  // Priority state; reset wipes all history
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_FU_TOTAL; i++) age_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_FU_TOTAL; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: doc/cdb_complete_arbiter.md
Name: cdb_complete_arbiter

Overview:
Grants the N common-data-bus completion slots each cycle to the functional units requesting to complete. It drives complete_gnt_bus, mult_cdb_en and ldst_cdb_en to execute, and so acts as the granting end of execute's completion handshake. It uses round-robin priority with a starvation override so multi-cycle units cannot be locked out by single-cycle ALU traffic. Requests from units on a squashed branch path are dropped in the same cycle as the mispredict.

Parameters:
N, 3, CDB width (completion slots per cycle)
NUM_FU_ALU, 3, ALU units; FU indices 0..NUM_FU_ALU-1
NUM_FU_MULT, 2, multiplier units; next indices
NUM_FU_BRANCH, 1, branch units; next indices
NUM_FU_LDST, 1, load/store units; highest indices
NUM_FU_TOTAL, 7, sum of the four counts above
STARVE_LIMIT, 4, waiting cycles before a requester gets slot-0 priority (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fu_req  in  NUM_FU_TOTAL  unit i has a result ready to complete this cycle
fu_b_mask  in  NUM_FU_TOTAL x B_MASK  branch mask of each requesting result
b_mm_resolve  in  B_MASK  branch being resolved this cycle
b_mm_mispred  in  1  the resolving branch mispredicted
complete_gnt_bus  out  N x NUM_FU_TOTAL  per-slot one-hot grant (all-zero = slot empty)
alu_cdb_en  out  NUM_FU_ALU  ALU granted this cycle
mult_cdb_en  out  NUM_FU_MULT  mult granted; the unit may advance its last stage
branch_cdb_en  out  NUM_FU_BRANCH  branch unit granted
ldst_cdb_en  out  NUM_FU_LDST  ldst granted
slots_used  out  clog2(N+1)  number of slots granted this cycle

Behaviour:
- Grant logic is combinational in the request cycle: execute samples the grants in the same cycle and completes on the CDB at the next clock edge.
- Squash: kill[i] = b_mm_mispred & |(fu_b_mask[i] & b_mm_resolve).
- Eligible set: e = fu_req & ~kill. A killed requester gets no grant and its age clears.
- Starved set: s[i] = e[i] & (age[i] >= STARVE_LIMIT).
- Slot 0:
  - If s is non-zero, grant the lowest-index member of s.
  - Otherwise grant the first eligible index at or after rr_ptr, in increasing index order with wrap-around.
- Slots 1..N-1: grant the next eligible, not-yet-granted indices in rotated order starting from rr_ptr, one per slot.
  - Slots fill contiguously from 0; an empty slot is never followed by a filled slot.
- Each FU receives at most one grant. Each slot is one-hot or zero.
- The *_cdb_en outputs are the OR across slots of the matching index slice. slots_used is the popcount of the filled slots.
- No eligible requests: all grant outputs are 0, and rr_ptr and ages hold.
- rr_ptr, width clog2(NUM_FU_TOTAL):
  - On any cycle with at least one grant, rr_ptr <= (FU index in the highest-numbered filled slot + 1) mod NUM_FU_TOTAL.
  - The wrap from NUM_FU_TOTAL-1 goes to 0.
- age[i], width clog2(STARVE_LIMIT+1):
  - If e[i] and not granted: age[i] saturating-increments, capped at STARVE_LIMIT.
  - Otherwise: age[i] <= 0.
- Reset: rr_ptr <= 0 and all ages <= 0. While reset is high, all grant outputs and slots_used are forced to 0 regardless of requests.
- Mid-operation reset discards all priority history. The first cycle after reset behaves as rr_ptr = 0.
- Fewer than N eligible requests: every eligible requester is granted.
- Simultaneous starvation and mispredict: squash is applied before the starvation check.

Decomposition:
- Shared package (sys_defs): N, the NUM_FU_* counts, B_MASK width, and the FU index base constants ALU_BASE, MULT_BASE, BRANCH_BASE, LDST_BASE.
- Sub-module rr_first_select:
  - Inputs: a request vector and a start pointer.
  - Outputs: the one-hot first set bit at or after the pointer, with wrap-around.
  - Instantiated N times in a chain, each stage masking out the previous grants.

Test Plan:
- Reset, then fu_req=7'b1111111 with no mispredict -> cycle 1 grants indices 0,1,2, rr_ptr=3; cycle 2 grants 3,4,5 (mult_cdb_en=2'b11, branch_cdb_en=1); cycle 3 grants 6,0,1.
- fu_req=7'b0001000 (mult0) alone -> slot0 one-hot bit3, slots 1-2 zero, mult_cdb_en=2'b01, slots_used=1.
- Hold mult1 (idx4) requesting while ALUs 0-2 always request and rr_ptr is parked so idx4 loses -> by the cycle its age reaches 4, idx4 owns slot 0; its age then returns to 0.
- b_mm_mispred=1, b_mm_resolve=0010, idx3 mask 0010 and idx0 mask 0000, both requesting -> only idx0 granted, idx3 age=0.
- Requests on every FU with reset asserted for one cycle mid-stream -> grants all zero during reset; next cycle grants 0,1,2.
- fu_req=7'b1000001 with rr_ptr=6 -> slot0=idx6, slot1=idx0, rr_ptr becomes 1.
